i2c_slave_receiver: RTL and testbench

I2C_SLAVE_RECEIVER -- requirements
Module: i2c_slave_receiver

---
 rtl/i2c_slave_receiver.sv | 181 ++++++++++++++++++
 tb/tb_i2c_slave_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_receiver.sv
// ---------------------------------------------------------------------------
// i2c_slave_receiver
//
// Write-only I2C responder. It watches the bus through a synchronizer and
// detects START and STOP. It acknowledges its own 7-bit address when the
// R/W bit is 0. Each following data byte goes to a consumer through a
// registered rx_data / rx_valid pair. The byte is ACKed only when the
// consumer is ready.
//
// Ports
//   clk       : system clock (only clock domain)
//   reset     : asynchronous, active-high reset
//   scl       : bus clock, already resolved from the open-drain line
//   sda_in    : bus data as seen on the wire
//   sda_oe    : 1 pulls SDA low (ACK), 0 releases it
//   rx_ready  : consumer can take a byte
//   rx_data   : last accepted data byte (MSB first on the wire)
//   rx_valid  : one-clk pulse when rx_data is updated
//   busy      : high from a START addressed to us until STOP
// ---------------------------------------------------------------------------
module i2c_slave_receiver #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2      // legal range 2..4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_e;

  // Synchronizers plus one delay flop per line for edge detection. They
  // reset to 1 because an idle bus is high.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_dly_q,  sda_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      // NOTE: registers are updated with <= so every flop samples the
      // pre-edge value, which gives a true shift chain rather than a wire.
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
      sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  // SDA may only change while SCL is high to signal START or STOP.
  assign start_det = scl_s & sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_dly_q & sda_s;

  state_e      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        sda_oe_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        busy_q;

  // shift_d is the byte including the bit being sampled. It is used to
  // decide on the 8th rising edge without waiting one more clk.
  assign shift_d = {shift_q[6:0], sda_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: defaulting rx_valid_q low every clk is what makes it a
      // single-cycle pulse; only the byte-accept branch raises it.
      rx_valid_q <= 1'b0;

      if (stop_det) begin
        state_q   <= IDLE;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (start_det) begin
        // Repeated START: busy is left alone until the new address resolves.
        state_q   <= ADDR;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;

          ADDR: begin
            if (scl_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd8;
                if (shift_d[7:1] == SLAVE_ADDR && !shift_d[0]) begin
                  state_q <= ADDR_ACK;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= IGNORE;
                  busy_q  <= 1'b0;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          // The first falling edge ends bit 8 and starts driving the ACK.
          // The second falling edge ends the 9th clock and releases SDA.
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= DATA;
              end
            end
          end

          DATA: begin
            if (scl_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd8;
                if (rx_ready) begin
                  rx_data_q  <= shift_d;
                  rx_valid_q <= 1'b1;
                  state_q    <= DATA_ACK;
                end else begin
                  state_q <= IGNORE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          IGNORE: sda_oe_q <= 1'b0;

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_receiver
//
// Directed I2C master transactions against i2c_slave_receiver. The master
// drives SCL and an open-drain SDA. The bus value is the wired-AND with
// the DUT pull-down. For every byte the DUT should deliver, the stimulus
// pushes the expected byte into a queue. A monitor pops the queue on each
// rx_valid pulse and compares.
// ---------------------------------------------------------------------------
module tb_i2c_slave_receiver;

  localparam int Q = 8;  // clk cycles per quarter of an SCL period

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  assign sda_bus = sda_m & ~sda_oe;

  always #10 clk = ~clk;

  i2c_slave_receiver #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  bit         oe_seen, busy_seen, valid_seen;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Scoreboard monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy)   busy_seen = 1'b1;
    if (rx_valid) begin
      valid_seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("rx_valid_unexpected", 32'd1, 32'd0);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_byte});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  // Sends one byte plus the 9th (ACK) clock. The bench checks the ACK
  // against exp_ack and checks that SDA is released after the 9th clock.
  // If push is set, the byte is queued as an expected delivery.
  task automatic tx_byte(input string name, input logic [7:0] b,
                         input logic ready, input logic exp_ack,
                         input logic push);
    logic ack;
    rx_ready = ready;
    if (push) exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = ~sda_bus;
    check({name, "_ack"}, {31'd0, ack}, {31'd0, exp_ack});
    wait_q();
    scl_m = 1'b0; wait_q();
    check({name, "_oe_release"}, {31'd0, sda_oe}, 32'd0);
  endtask

  task automatic clear_flags();
    oe_seen = 1'b0; busy_seen = 1'b0; valid_seen = 1'b0;
  endtask

  initial begin
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_rx_data",  {24'd0, rx_data},  32'd0);
    reset = 1'b0;
    wait_q();

    // Write to our address, one byte accepted.
    i2c_start();
    tx_byte("t30_addr", 8'hA0, 1'b1, 1'b1, 1'b0);
    check("t30_busy_on", {31'd0, busy}, 32'd1);
    tx_byte("t30_data", 8'h3C, 1'b1, 1'b1, 1'b1);
    check("t30_busy_hold", {31'd0, busy}, 32'd1);
    i2c_stop(); wait_q();
    check("t30_busy_off", {31'd0, busy}, 32'd0);
    check("t30_rx_data", {24'd0, rx_data}, 32'h3C);

    // Foreign address: never drive SDA, never busy, ignore data.
    clear_flags();
    i2c_start();
    tx_byte("t31_addr", 8'hA2, 1'b1, 1'b0, 1'b0);
    tx_byte("t31_data", 8'h55, 1'b1, 1'b0, 1'b0);
    i2c_stop(); wait_q();
    check("t31_oe_seen",    {31'd0, oe_seen},    32'd0);
    check("t31_busy_seen",  {31'd0, busy_seen},  32'd0);
    check("t31_valid_seen", {31'd0, valid_seen}, 32'd0);

    // Our address with the read bit set: NACK.
    clear_flags();
    i2c_start();
    tx_byte("t32_addr", 8'hA1, 1'b1, 1'b0, 1'b0);
    tx_byte("t32_data", 8'h66, 1'b1, 1'b0, 1'b0);
    i2c_stop(); wait_q();
    check("t32_busy_seen",  {31'd0, busy_seen},  32'd0);
    check("t32_valid_seen", {31'd0, valid_seen}, 32'd0);

    // Back-pressure: second byte NACKed, the rest of the transfer ignored.
    i2c_start();
    tx_byte("t33_addr",  8'hA0, 1'b0, 1'b1, 1'b0);
    tx_byte("t33_data1", 8'h11, 1'b1, 1'b1, 1'b1);
    tx_byte("t33_data2", 8'h22, 1'b0, 1'b0, 1'b0);
    tx_byte("t33_data3", 8'h33, 1'b1, 1'b0, 1'b0);
    i2c_stop(); wait_q();
    check("t33_rx_data", {24'd0, rx_data}, 32'h11);
    check("t33_busy_off", {31'd0, busy}, 32'd0);

    // Repeated START after a partial byte.
    i2c_start();
    tx_byte("t34_addr1", 8'hA0, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_start();
    check("t34_busy_hold", {31'd0, busy}, 32'd1);
    tx_byte("t34_addr2", 8'hA0, 1'b1, 1'b1, 1'b0);
    tx_byte("t34_data",  8'h5A, 1'b1, 1'b1, 1'b1);
    i2c_stop(); wait_q();
    check("t34_rx_data", {24'd0, rx_data}, 32'h5A);

    // Reset asserted while the ACK is driven.
    i2c_start();
    rx_ready = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(logic'((8'hA0 >> i) & 8'h01));
    check("t35_oe_before_rst", {31'd0, sda_oe}, 32'd1);
    #3 reset = 1'b1;
    #1 check("t35_oe_async", {31'd0, sda_oe}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t35_busy_after_rst", {31'd0, busy}, 32'd0);
    clear_flags();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
    tx_byte("t35_stale", 8'h99, 1'b1, 1'b0, 1'b0);
    i2c_stop(); wait_q();
    check("t35_valid_seen", {31'd0, valid_seen}, 32'd0);
    i2c_start();
    tx_byte("t35_addr", 8'hA0, 1'b1, 1'b1, 1'b0);
    tx_byte("t35_data", 8'h77, 1'b1, 1'b1, 1'b1);
    i2c_stop(); wait_q();
    check("t35_rx_data", {24'd0, rx_data}, 32'h77);

    repeat (20) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
